// File: rtl/tx_sop_frame_gen_if.sv
// Sample-stream bundle between upstream payload source, frame generator and modulator.
// slave is the generator's view; master is the view of whatever drives and observes it.
interface tx_sop_frame_gen_if #(
  parameter int DW = 16
) ();
  logic          en;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          sop;
  logic          eop;
  logic [15:0]   frame_cnt;
  logic [15:0]   underrun_cnt;

  modport master (
    output en, s_data, s_valid,
    input  s_ready, m_data, m_valid, sop, eop, frame_cnt, underrun_cnt
  );

  modport slave (
    input  en, s_data, s_valid,
    output s_ready, m_data, m_valid, sop, eop, frame_cnt, underrun_cnt
  );
endinterface

// File: rtl/tx_sop_frame_gen.sv
// Frame generator: PN preamble (sop on first sample), upstream payload, zero guard (eop on last).
// One sample per clk, outputs registered one cycle; s_ready is high for every payload slot, never stalls.
module tx_sop_frame_gen #(
  parameter int            FRAME_LEN = 52800,
  parameter int            PRE_LEN   = 64,
  parameter int            GUARD_LEN = 16,
  parameter int            DW        = 16,
  parameter logic [DW-1:0] AMP       = 16'd8192
) (
  input  logic              clk,
  input  logic              rst_n,
  tx_sop_frame_gen_if.slave bus
);

  localparam int            PAY_LEN    = FRAME_LEN - PRE_LEN - GUARD_LEN;
  localparam int            CW         = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] PRE_LAST   = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST   = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_LEN - 1);
  localparam logic [DW-1:0] NEG_AMP    = ~AMP + 1'b1;
  localparam logic [6:0]    LFSR_SEED  = 7'h7F;

  if (PRE_LEN < 1 || GUARD_LEN < 1 || FRAME_LEN < PRE_LEN + GUARD_LEN + 2) begin : g_bad_params
    $error("tx_sop_frame_gen: illegal FRAME_LEN/PRE_LEN/GUARD_LEN combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_PAY,
    ST_GUARD
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_scnt;
  logic [6:0]    r_lfsr;
  logic [DW-1:0] r_m_data;
  logic          r_m_valid;
  logic          r_sop;
  logic          r_eop;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   r_underrun_cnt;

  state_t        w_state_nxt;
  logic [CW-1:0] w_scnt_nxt;
  logic [6:0]    w_lfsr_nxt;
  logic [DW-1:0] w_m_data_nxt;
  logic          w_m_valid_nxt;
  logic          w_sop_nxt;
  logic          w_eop_nxt;
  logic          w_frame_inc;
  logic          w_underrun_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_scnt    <= '0;
      r_lfsr    <= LFSR_SEED;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_scnt    <= w_scnt_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_sop     <= w_sop_nxt;
      r_eop     <= w_eop_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_frame_inc) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_underrun_inc && r_underrun_cnt != 16'hFFFF) begin
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
    end
  end

  // scnt restarts at zero on every state entry; the LFSR is reseeded whenever PRE is entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_scnt_nxt     = r_scnt + 1'b1;
    w_lfsr_nxt     = r_lfsr;
    w_m_data_nxt   = '0;
    w_m_valid_nxt  = 1'b0;
    w_sop_nxt      = 1'b0;
    w_eop_nxt      = 1'b0;
    w_frame_inc    = 1'b0;
    w_underrun_inc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_scnt_nxt = '0;
        if (bus.en) begin
          w_state_nxt = ST_PRE;
          w_lfsr_nxt  = LFSR_SEED;
        end
      end
      ST_PRE: begin
        w_m_valid_nxt = 1'b1;
        w_m_data_nxt  = r_lfsr[0] ? AMP : NEG_AMP;
        w_sop_nxt     = (r_scnt == '0);
        w_lfsr_nxt    = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        if (r_scnt == PRE_LAST) begin
          w_state_nxt = ST_PAY;
          w_scnt_nxt  = '0;
        end
      end
      ST_PAY: begin
        w_m_valid_nxt = 1'b1;
        if (bus.s_valid) begin
          w_m_data_nxt = bus.s_data;
        end else begin
          w_underrun_inc = 1'b1;
        end
        if (r_scnt == PAY_LAST) begin
          w_state_nxt = ST_GUARD;
          w_scnt_nxt  = '0;
        end
      end
      ST_GUARD: begin
        w_m_valid_nxt = 1'b1;
        if (r_scnt == GUARD_LAST) begin
          w_eop_nxt   = 1'b1;
          w_frame_inc = 1'b1;
          w_scnt_nxt  = '0;
          if (bus.en) begin
            w_state_nxt = ST_PRE;
            w_lfsr_nxt  = LFSR_SEED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_scnt_nxt  = '0;
      end
    endcase
  end

  assign bus.s_ready      = (r_state == ST_PAY);
  assign bus.m_data       = r_m_data;
  assign bus.m_valid      = r_m_valid;
  assign bus.sop          = r_sop;
  assign bus.eop          = r_eop;
  assign bus.frame_cnt    = r_frame_cnt;
  assign bus.underrun_cnt = r_underrun_cnt;

endmodule
